// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest commit queue.
//   - DEF_* : default configuration (commit lanes, PC/data width, queue depth)
//   - CNT_W : width of a per-group entry count (covers 0..8 lanes)
//   - entry_t : one retired instruction {pc, data} at the default width;
//     parameterised instances use the same {pc, data} bit order in flat
//     2*XLEN-bit slots
//   - popcount : number of set bits in a (zero-extended) lane mask
package difftest_pkg;

  localparam int DEF_COMMIT_W = 2;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_DEPTH    = 16;
  localparam int MAX_COMMIT_W = 8;
  localparam int CNT_W        = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] data;
  } entry_t;

  function automatic logic [7:0] popcount(input logic [MAX_COMMIT_W-1:0] mask);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_COMMIT_W; i++) begin
      n = n + {7'd0, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/commit_lane_packer.sv
// Lane compaction for one commit group (purely combinational).
// The valid lanes are squeezed, in ascending lane order, into the low
// slots of slot_entry; holes (invalid lanes) are skipped.
// Ports:
//   lane_valid  : per-lane retire valid
//   lane_pc     : lane i PC at [i*XLEN +: XLEN]
//   lane_data   : lane i writeback data, same packing
//   slot_entry  : packed {pc, data} per slot, slot 0 = lowest valid lane
//   slot_count  : number of valid lanes (= number of meaningful slots)
module commit_lane_packer
  import difftest_pkg::*;
#(
  parameter int COMMIT_W = DEF_COMMIT_W,
  parameter int XLEN     = DEF_XLEN
) (
  input  logic [COMMIT_W-1:0]                 lane_valid,
  input  logic [COMMIT_W*XLEN-1:0]            lane_pc,
  input  logic [COMMIT_W*XLEN-1:0]            lane_data,
  output logic [COMMIT_W-1:0][2*XLEN-1:0]     slot_entry,
  output logic [CNT_W-1:0]                    slot_count
);

  localparam int SEL_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  logic [CNT_W-1:0] cnt;

  // A running count of valid lanes seen so far is the destination slot of
  // the next valid lane; it never exceeds the lane index, so it stays in range.
  always_comb begin
    slot_entry = '0;
    cnt        = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (lane_valid[SEL_W'(i)]) begin
        slot_entry[cnt[SEL_W-1:0]] = {lane_pc[i*XLEN +: XLEN], lane_data[i*XLEN +: XLEN]};
        cnt = cnt + CNT_W'(1);
      end
    end
    slot_count = cnt;
  end

endmodule

// File: rtl/difftest_commit_queue.sv
// Difftest commit queue: absorbs up to COMMIT_W retired instructions per
// cycle from the core and replays them one per cycle to a checker.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   commit_valid/pc/data: per-lane retire group (lane i at [i*XLEN +: XLEN])
//   commit_num          : retire count claimed by the core (cross-checked)
//   commit_ready        : a full group of COMMIT_W entries fits
//   out_valid/out_ready : serialized checker stream handshake
//   out_pc/out_data     : head entry (zero when the queue is empty)
//   out_seq             : retire sequence number of the head entry
//   occupancy           : current entry count
//   err_overflow        : sticky, a group arrived while commit_ready was 0
//   err_num             : sticky, commit_num disagreed with the valid mask
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int COMMIT_W = DEF_COMMIT_W,
  parameter int XLEN     = DEF_XLEN,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [COMMIT_W-1:0]        commit_valid,
  input  logic [COMMIT_W*XLEN-1:0]   commit_pc,
  input  logic [COMMIT_W*XLEN-1:0]   commit_data,
  input  logic [7:0]                 commit_num,
  output logic                       commit_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_data,
  output logic [31:0]                out_seq,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_overflow,
  output logic                       err_num
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [COMMIT_W-1:0][2*XLEN-1:0] slot_entry;
  logic [CNT_W-1:0]                slot_count;
  logic [CNT_W-1:0]                enq_count;
  logic [OCC_W-1:0]                free_slots;
  logic [OCC_W-1:0]                occ_next;
  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic                            deq;
  logic                            num_mismatch;
  logic [2*XLEN-1:0]               head;
  logic [2*XLEN-1:0]               mem [DEPTH];

  commit_lane_packer #(
    .COMMIT_W (COMMIT_W),
    .XLEN     (XLEN)
  ) u_packer (
    .lane_valid (commit_valid),
    .lane_pc    (commit_pc),
    .lane_data  (commit_data),
    .slot_entry (slot_entry),
    .slot_count (slot_count)
  );

  // Enqueue side: admission is judged on the registered occupancy only; a
  // dequeue in the same cycle is deliberately not credited, so commit_ready
  // never depends on out_ready.
  assign free_slots   = OCC_W'(DEPTH) - occupancy;
  assign commit_ready = (free_slots >= OCC_W'(COMMIT_W));
  assign enq_count    = commit_ready ? slot_count : '0;
  assign num_mismatch = (commit_num != popcount(MAX_COMMIT_W'(commit_valid)));

  // Dequeue side: the head is read from storage, so a freshly written entry
  // shows up only after its enqueue edge. Empty/full come from occupancy,
  // because rd_ptr == wr_ptr is ambiguous once the pointers wrap.
  assign out_valid = (occupancy != '0);
  assign deq       = out_valid & out_ready;
  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head[2*XLEN-1:XLEN] : '0;
  assign out_data  = out_valid ? head[XLEN-1:0]      : '0;
  assign occ_next  = occupancy + OCC_W'(enq_count) - OCC_W'(deq);

  // Storage carries no reset: discarding the queue only needs the pointers
  // and occupancy cleared.
  always_ff @(posedge clock) begin
    for (int k = 0; k < COMMIT_W; k++) begin
      if (CNT_W'(k) < enq_count) begin
        mem[wr_ptr + PTR_W'(k)] <= slot_entry[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      out_seq      <= '0;
      err_overflow <= 1'b0;
      err_num      <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(enq_count);
      rd_ptr    <= rd_ptr + PTR_W'(deq);
      occupancy <= occ_next;
      if (deq) begin
        out_seq <= out_seq + 32'd1;
      end
      if (!commit_ready && (commit_valid != '0)) begin
        err_overflow <= 1'b1;
      end
      if (num_mismatch) begin
        err_num <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
module tb_difftest_commit_queue;
  import difftest_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] commit_data;
  logic [7:0]  commit_num;
  logic        commit_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [31:0] out_seq;
  logic [4:0]  occupancy;
  logic        err_overflow;
  logic        err_num;

  // single-lane instance used for the 15-entry dequeue+enqueue corner
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_data;
  logic [7:0]  s_num;
  logic        s_ready;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_pc;
  logic [31:0] s_out_data;
  logic [31:0] s_out_seq;
  logic [4:0]  s_occ;
  logic        s_ovf;
  logic        s_enum;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_seq;

  difftest_commit_queue dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_data(commit_data),
    .commit_num(commit_num), .commit_ready(commit_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_seq(out_seq), .occupancy(occupancy),
    .err_overflow(err_overflow), .err_num(err_num)
  );

  difftest_commit_queue #(.COMMIT_W(1), .XLEN(32), .DEPTH(16)) dut1 (
    .clock(clock), .reset(reset),
    .commit_valid(s_valid), .commit_pc(s_pc), .commit_data(s_data),
    .commit_num(s_num), .commit_ready(s_ready),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pc(s_out_pc), .out_data(s_out_data),
    .out_seq(s_out_seq), .occupancy(s_occ),
    .err_overflow(s_ovf), .err_num(s_enum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] pc0, pc1, d0, d1;
    logic [7:0]  num;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc, e_data, e_seq;
    logic [4:0]  e_occ;
    logic        e_ready;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [7:0] n, input logic r);
    commit_valid = v;
    commit_pc    = {p1, p0};
    commit_data  = {~p1, ~p0};
    commit_num   = n;
    out_ready    = r;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    entry_t e;
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    s_valid = 1'b0; s_pc = '0; s_data = '0; s_num = 8'd0; s_out_ready = 1'b0;

    tbl[0] = '{2'b11, 32'h80000000, 32'h80000004, 32'h11, 32'h22, 8'd2, 1'b1,
               1'b1, 32'h80000000, 32'h11, 32'd0, 5'd2, 1'b1};
    tbl[1] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 1'b1,
               1'b1, 32'h80000004, 32'h22, 32'd1, 5'd1, 1'b1};
    tbl[2] = '{2'b10, 32'h0, 32'h80000010, 32'h0, 32'h33, 8'd1, 1'b1,
               1'b1, 32'h80000010, 32'h33, 32'd2, 5'd1, 1'b1};
    tbl[3] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 1'b1,
               1'b0, 32'h0, 32'h0, 32'd3, 5'd0, 1'b1};
    tbl[4] = '{2'b01, 32'h80000020, 32'h0, 32'h44, 32'h0, 8'd1, 1'b0,
               1'b1, 32'h80000020, 32'h44, 32'd3, 5'd1, 1'b1};
    tbl[5] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0,
               1'b1, 32'h80000020, 32'h44, 32'd3, 5'd1, 1'b1};
    tbl[6] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 1'b1,
               1'b0, 32'h0, 32'h0, 32'd4, 5'd0, 1'b1};

    // reset state while reset is held low
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ready", 64'(commit_ready), 64'd1);
    chk("rst_seq", 64'(out_seq), 64'd0);
    chk("rst_pc_data", {out_pc, out_data}, 64'd0);
    chk("rst_errs", {62'd0, err_overflow, err_num}, 64'd0);
    step();
    step();
    reset = 1'b1;

    // table: apply at negedge, compare after the following rising edge
    for (int i = 0; i < 7; i++) begin
      commit_valid = tbl[i].valid;
      commit_pc    = {tbl[i].pc1, tbl[i].pc0};
      commit_data  = {tbl[i].d1, tbl[i].d0};
      commit_num   = tbl[i].num;
      out_ready    = tbl[i].rdy;
      step();
      e.pc = out_pc;
      e.data = out_data;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("v%0d_entry", i), 64'(e), {tbl[i].e_pc, tbl[i].e_data});
      chk($sformatf("v%0d_seq", i), 64'(out_seq), 64'(tbl[i].e_seq));
      chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("v%0d_ready", i), 64'(commit_ready), 64'(tbl[i].e_ready));
      chk($sformatf("v%0d_errs", i), {62'd0, err_overflow, err_num}, 64'd0);
    end
    exp_seq = 32'd4;

    // fill to DEPTH with out_ready low, then overflow with a 9th group
    for (int g = 0; g < 8; g++) begin
      drive(2'b11, 32'h1000 + 32'(8*g), 32'h1004 + 32'(8*g), 8'd2, 1'b0);
      step();
      chk($sformatf("fill_occ%0d", g), 64'(occupancy), 64'(2*(g+1)));
    end
    chk("full_ready", 64'(commit_ready), 64'd0);
    chk("full_head", {out_pc, out_data}, {32'h1000, ~32'h1000});
    drive(2'b11, 32'h9000, 32'h9004, 8'd2, 1'b0);
    step();
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_occ", 64'(occupancy), 64'd16);
    chk("ovf_head", 64'(out_pc), 64'h1000);
    chk("ovf_errnum", 64'(err_num), 64'd0);
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_pc%0d", i), 64'(out_pc), 64'(32'h1000 + 32'(4*i)));
      chk($sformatf("drain_seq%0d", i), 64'(out_seq), 64'(exp_seq));
      step();
      exp_seq++;
    end
    chk("drain_empty", {62'd0, out_valid, occupancy != 5'd0}, 64'd0);

    // 15 entries, then dequeue-only and dequeue+enqueue across the wrap
    for (int g = 0; g < 7; g++) begin
      drive(2'b11, 32'h2000 + 32'(8*g), 32'h2004 + 32'(8*g), 8'd2, 1'b0);
      step();
    end
    drive(2'b01, 32'h2038, 32'h0, 8'd1, 1'b0);
    step();
    chk("f15_occ", 64'(occupancy), 64'd15);
    chk("f15_ready", 64'(commit_ready), 64'd0);
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b1);
    step();
    exp_seq++;
    chk("f14_occ", 64'(occupancy), 64'd14);
    drive(2'b10, 32'h0, 32'h203C, 8'd1, 1'b1);
    step();
    exp_seq++;
    chk("enqdeq_occ", 64'(occupancy), 64'd14);
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("wrap_pc%0d", i), 64'(out_pc), 64'(32'h2008 + 32'(4*i)));
      chk($sformatf("wrap_seq%0d", i), 64'(out_seq), 64'(exp_seq));
      step();
      exp_seq++;
    end
    chk("wrap_empty", 64'(occupancy), 64'd0);

    // commit_num disagreeing with the mask; flag must stay sticky
    drive(2'b11, 32'h4000, 32'h4004, 8'd1, 1'b1);
    step();
    chk("errnum_set", 64'(err_num), 64'd1);
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b1);
    repeat (100) step();
    chk("errnum_sticky", 64'(err_num), 64'd1);
    chk("ovf_sticky", 64'(err_overflow), 64'd1);
    chk("idle_occ", 64'(occupancy), 64'd0);

    // asynchronous reset with 5 entries queued
    drive(2'b11, 32'h5000, 32'h5004, 8'd2, 1'b0);
    step();
    drive(2'b11, 32'h5008, 32'h500C, 8'd2, 1'b0);
    step();
    drive(2'b01, 32'h5010, 32'h0, 8'd1, 1'b0);
    step();
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_ready", 64'(commit_ready), 64'd1);
    chk("arst_pc_data", {out_pc, out_data}, 64'd0);
    chk("arst_seq", 64'(out_seq), 64'd0);
    chk("arst_errs", {62'd0, err_overflow, err_num}, 64'd0);
    step();
    reset = 1'b1;
    drive(2'b01, 32'h6000, 32'h0, 8'd1, 1'b0);
    step();
    chk("post_rst_pc", 64'(out_pc), 64'h6000);
    chk("post_rst_seq", 64'(out_seq), 64'd0);
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    drive(2'b00, 32'h0, 32'h0, 8'd0, 1'b1);
    step();
    chk("post_rst_drain", {27'd0, occupancy, out_seq}, 64'd1);

    // single-lane queue at 15 entries: dequeue+enqueue keeps 15, order kept
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1; s_pc = 32'h7000 + 32'(4*i); s_data = ~s_pc; s_num = 8'd1;
      step();
    end
    chk("s_occ15", 64'(s_occ), 64'd15);
    chk("s_ready15", 64'(s_ready), 64'd1);
    s_out_ready = 1'b1;
    s_pc = 32'h703C; s_data = ~s_pc;
    step();
    chk("s_enqdeq_occ", 64'(s_occ), 64'd15);
    chk("s_enqdeq_head", 64'(s_out_pc), 64'h7004);
    s_pc = 32'h7040; s_data = ~s_pc;
    step();
    chk("s_wrap_occ", 64'(s_occ), 64'd15);
    s_valid = 1'b0; s_num = 8'd0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("s_drain_pc%0d", i), {s_out_pc, s_out_data},
          {32'h7008 + 32'(4*i), ~(32'h7008 + 32'(4*i))});
      step();
    end
    chk("s_end", {27'd0, s_occ, s_out_seq}, 64'd17);
    chk("s_errs", {62'd0, s_ovf, s_enum}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_commit_queue.md
DIFFTEST_COMMIT_QUEUE -- requirements
Module: difftest_commit_queue

Interface
REQ-001 The block SHALL have parameter COMMIT_W, default 2, giving the number of commit lanes (1..8).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the PC/data width.
REQ-003 The block SHALL have parameter DEPTH, default 16, giving queue entries (power of 2, >= 2*COMMIT_W).
REQ-004 The block SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 The block SHALL have port commit_valid  input  COMMIT_W  per-lane retire valid.
REQ-007 The block SHALL have port commit_pc  input  COMMIT_W*XLEN  lane i PC at [i*XLEN +: XLEN].
REQ-008 The block SHALL have port commit_data  input  COMMIT_W*XLEN  lane i writeback data, same packing.
REQ-009 The block SHALL have port commit_num  input  8  retire count claimed by the core.
REQ-010 The block SHALL have port commit_ready  output  1  queue can absorb a full commit group.
REQ-011 The block SHALL have ports out_valid  output  1, out_ready  input  1, and out_pc / out_data  output  XLEN, forming the serialized checker stream.
REQ-012 The block SHALL have port out_seq  output  32  retire sequence number of the head entry.
REQ-013 The block SHALL have port occupancy  output  clog2(DEPTH)+1  current entry count.
REQ-014 The block SHALL have ports err_overflow / err_num  output  1  sticky error flags.

Function
REQ-015 commit_ready SHALL be 1 iff DEPTH - occupancy >= COMMIT_W, computed from the registered occupancy without crediting a same-cycle dequeue.
REQ-016 When commit_ready=1, each set commit_valid lane SHALL enqueue one {pc,data} entry; entries SHALL be packed in ascending lane order into consecutive slots, skipping invalid lanes (holes).
REQ-017 When commit_ready=0 and commit_valid != 0, the whole group SHALL be dropped and err_overflow SHALL set.
REQ-018 Enqueued entries SHALL become visible at the output one cycle after the enqueue edge; there is no same-cycle bypass.
REQ-019 out_valid SHALL equal (occupancy != 0); out_pc, out_data and out_seq SHALL show the head entry and hold stable while out_valid=1 and out_ready=0.
REQ-020 One entry SHALL dequeue per cycle when out_valid and out_ready are both 1.
REQ-021 On simultaneous enqueue of n entries and a dequeue, occupancy SHALL become occupancy + n - 1.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; full versus empty SHALL be resolved by occupancy, not by pointer equality.
REQ-023 out_seq SHALL be a 32-bit counter, incremented on each dequeue and wrapping from 0xFFFFFFFF to 0.
REQ-024 err_num SHALL set in any cycle where commit_num differs from popcount(commit_valid), regardless of commit_ready.
REQ-025 Error flags SHALL remain set until reset.

Reset
REQ-026 While reset=0, pointers, occupancy, out_seq, out_valid, err_overflow and err_num SHALL be 0, commit_ready SHALL be 1, and out_pc/out_data SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronously), and no partial group SHALL survive.
REQ-028 Reset deassertion SHALL take effect at the next clock edge, and the first accepted commit SHALL carry out_seq 0.

Structure
REQ-029 Package difftest_pkg SHALL hold the entry struct {pc, data}, the default parameter constants, and the popcount function.
REQ-030 Lane compaction SHALL live in sub-module commit_lane_packer (valid mask in, packed entries plus count out, purely combinational); storage and control SHALL remain in difftest_commit_queue.

Verification
REQ-031 Both lanes valid, pc 0x80000000/0x80000004, commit_num=2, out_ready=1 -> next cycle out_pc=0x80000000 with seq 0, then 0x80000004 with seq 1; err flags stay 0.
REQ-032 commit_valid=2'b10 (hole in lane 0), pc1=0x80000010, commit_num=1 -> single entry 0x80000010 emitted; occupancy peaks at 1.
REQ-033 out_ready=0 with 8 two-lane groups -> occupancy=16, commit_ready=0; a 9th group is dropped and err_overflow=1; out_pc holds the first entry.
REQ-034 Queue at 15 entries with simultaneous dequeue and 1-lane enqueue -> occupancy stays 15; pointer wrap past slot 15 preserves order.
REQ-035 commit_valid=2'b11 with commit_num=1 -> err_num=1 next cycle and still 1 after 100 idle cycles.
REQ-036 reset pulled low with 5 entries queued -> out_valid=0 and occupancy=0 immediately; after release, a new commit appears with out_seq=0.
